// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan controller: FSM states,
// colour-field indices within a framebuffer word, and BCM on-time rule.
package hub75_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        LATCH   = 2'd2,
        DISPLAY = 2'd3
    } state_t;

    localparam int R1_I       = 0;
    localparam int G1_I       = 1;
    localparam int B1_I       = 2;
    localparam int R2_I       = 3;
    localparam int G2_I       = 4;
    localparam int B2_I       = 5;
    localparam int NUM_FIELDS = 6;

    // Binary-weighted display time: plane p is lit for base << p cycles.
    function automatic int on_cycles(input int base, input int plane);
        return base << plane;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// BCM on-time timer: loads the on-time of a bit-plane, holds OE low while
// counting down, and flags the final lit cycle so the scheduler can advance.
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int BASE_ON = 16,
    parameter int BPP     = 4,
    parameter int PLANE_W = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [PLANE_W-1:0] i_plane,
    output logic               o_oe,
    output logic               o_done
);

    localparam int CNT_W = $clog2((BASE_ON << (BPP - 1)) + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(on_cycles(BASE_ON, int'(i_plane)));
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_oe   = (r_cnt == '0);
    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan/BCM scheduler: per row and bit-plane it shifts one plane of the
// framebuffer onto the panel, latches it, selects the row and lights it.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int COLS    = 64,
    parameter int ROWS    = 32,
    parameter int BPP     = 4,
    parameter int CLK_DIV = 4,
    parameter int BASE_ON = 16
) (
    input  logic                                 CLK100MHZ,
    input  logic                                 CPU_RESETN,
    input  logic                                 en,
    output logic                                 fb_rd,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0] fb_addr,
    input  logic [NUM_FIELDS*BPP-1:0]            fb_data,
    output logic                                 A,
    output logic                                 B,
    output logic                                 C,
    output logic                                 D,
    output logic                                 E,
    output logic                                 CLK,
    output logic                                 R1,
    output logic                                 G1,
    output logic                                 B1,
    output logic                                 R2,
    output logic                                 G2,
    output logic                                 B2,
    output logic                                 LAT,
    output logic                                 OE,
    output logic                                 frame_done
);

    localparam int COL_W   = $clog2(COLS);
    localparam int ROW_W   = $clog2(ROWS);
    localparam int PLANE_W = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int TICK_W  = $clog2(2 * CLK_DIV);
    localparam logic [TICK_W-1:0] TICK_HI   = TICK_W'(CLK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(2 * CLK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_RD   = TICK_W'(2 * CLK_DIV - 2);

    state_t             r_state, w_next;
    logic [ROW_W-1:0]   r_row, r_addr;
    logic [PLANE_W-1:0] r_plane;
    logic [COL_W-1:0]   r_col, w_rd_col;
    logic [TICK_W-1:0]  r_tick;
    logic               r_pre, r_rd_q, r_frame_done;
    logic [NUM_FIELDS-1:0] r_rgb;
    logic [BPP-1:0]     w_field [NUM_FIELDS];
    logic               w_col_end, w_shift_end, w_latch_end, w_bcm_done;
    logic               w_plane_last, w_row_last, w_oe;

    assign w_col_end    = (r_state == SHIFT) && !r_pre && (r_tick == TICK_LAST);
    assign w_shift_end  = w_col_end && (r_col == COL_W'(COLS - 1));
    assign w_latch_end  = (r_state == LATCH) && (r_tick == TICK_HI);
    assign w_plane_last = (r_plane == PLANE_W'(BPP - 1));
    assign w_row_last   = (r_row == ROW_W'(ROWS - 1));

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (en) w_next = SHIFT;
            SHIFT:   if (w_shift_end) w_next = LATCH;
            LATCH:   if (w_latch_end) w_next = DISPLAY;
            DISPLAY: if (w_bcm_done) w_next = en ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_pre marks the extra read cycle that primes column 0 of each plane.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_row        <= '0;
            r_plane      <= '0;
            r_col        <= '0;
            r_tick       <= '0;
            r_pre        <= 1'b0;
            r_addr       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_col  <= '0;
                    r_tick <= '0;
                    r_pre  <= en;
                end
                SHIFT: begin
                    if (r_pre) begin
                        r_pre  <= 1'b0;
                        r_tick <= '0;
                    end else if (w_col_end) begin
                        r_tick <= '0;
                        r_col  <= r_col + 1'b1;
                        if (w_shift_end) r_addr <= r_row;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                LATCH: r_tick <= w_latch_end ? '0 : r_tick + 1'b1;
                DISPLAY: begin
                    if (w_bcm_done) begin
                        r_pre  <= en;
                        r_col  <= '0;
                        r_tick <= '0;
                        r_frame_done <= w_plane_last && w_row_last;
                        if (!en) begin
                            r_row   <= '0;
                            r_plane <= '0;
                        end else if (w_plane_last) begin
                            r_plane <= '0;
                            r_row   <= w_row_last ? '0 : r_row + 1'b1;
                        end else begin
                            r_plane <= r_plane + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Reads for columns after the first land so new pixel bits appear as CLK falls.
    assign w_rd_col = (r_state == SHIFT && !r_pre) ? r_col + 1'b1 : r_col;
    assign fb_rd    = (r_state == SHIFT) &&
                      (r_pre || (!r_pre && r_tick == TICK_RD && r_col != COL_W'(COLS - 1)));
    assign fb_addr  = {r_row, w_rd_col};

    always_comb begin
        for (int k = 0; k < NUM_FIELDS; k++) begin
            w_field[k] = fb_data[k*BPP +: BPP];
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_rd_q <= 1'b0;
            r_rgb  <= '0;
        end else begin
            r_rd_q <= fb_rd;
            if (r_rd_q) begin
                for (int k = 0; k < NUM_FIELDS; k++) begin
                    r_rgb[k] <= w_field[k][r_plane];
                end
            end
        end
    end

    hub75_bcm_timer #(
        .BASE_ON (BASE_ON),
        .BPP     (BPP),
        .PLANE_W (PLANE_W)
    ) u_bcm (
        .i_clk   (CLK100MHZ),
        .i_rst_n (CPU_RESETN),
        .i_load  (w_latch_end),
        .i_plane (r_plane),
        .o_oe    (w_oe),
        .o_done  (w_bcm_done)
    );

    assign OE              = w_oe;
    assign LAT             = (r_state == LATCH) && (r_tick != '0);
    assign CLK             = (r_state == SHIFT) && !r_pre && (r_tick >= TICK_HI);
    assign {E, D, C, B, A} = 5'(r_addr);
    assign R1              = r_rgb[R1_I];
    assign G1              = r_rgb[G1_I];
    assign B1              = r_rgb[B1_I];
    assign R2              = r_rgb[R2_I];
    assign G2              = r_rgb[G2_I];
    assign B2              = r_rgb[B2_I];
    assign frame_done      = r_frame_done;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: a full-size panel instance checked plane by plane
// against a framebuffer model, plus a reduced-timing instance for the frame wrap.
module tb_hub75_scan_ctrl;

    localparam int COLS = 64, ROWS = 32, BPP = 4, CLK_DIV = 4, BASE_ON = 16;
    localparam int FCOLS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, en_f;
    logic        fb_rd;
    logic [10:0] fb_addr;
    logic [23:0] fb_data = '0;
    logic        A, B, C, D, E, PCLK, R1, G1, B1, R2, G2, B2, LAT, OE, frame_done;

    logic        fb_rd_f;
    logic [7:0]  fb_addr_f;
    logic [23:0] fb_data_f = '0;
    logic        A_f, B_f, C_f, D_f, E_f, PCLK_f, R1_f, G1_f, B1_f, R2_f, G2_f, B2_f;
    logic        LAT_f, OE_f, frame_done_f;

    logic [23:0] mem [2048];
    int errors = 0;
    int checks = 0;

    hub75_scan_ctrl dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .en(en),
        .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
        .A(A), .B(B), .C(C), .D(D), .E(E), .CLK(PCLK),
        .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .LAT(LAT), .OE(OE), .frame_done(frame_done)
    );

    hub75_scan_ctrl #(.COLS(FCOLS), .ROWS(32), .BPP(4), .CLK_DIV(1), .BASE_ON(2)) dut_f (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .en(en_f),
        .fb_rd(fb_rd_f), .fb_addr(fb_addr_f), .fb_data(fb_data_f),
        .A(A_f), .B(B_f), .C(C_f), .D(D_f), .E(E_f), .CLK(PCLK_f),
        .R1(R1_f), .G1(G1_f), .B1(B1_f), .R2(R2_f), .G2(G2_f), .B2(B2_f),
        .LAT(LAT_f), .OE(OE_f), .frame_done(frame_done_f)
    );

    // Framebuffer RAM with 1-cycle read latency; garbage on non-read cycles.
    always @(posedge clk) begin
        fb_data   <= fb_rd ? mem[fb_addr] : 24'($urandom);
        fb_data_f <= 24'($urandom);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] exp_bits(input logic [23:0] w, input int plane);
        logic [5:0] r;
        for (int k = 0; k < 6; k++) r[k] = w[k*BPP + plane];
        return r;
    endfunction

    // Follows one row/plane from its shift through to OE returning high.
    task automatic observe_plane(input int row, input int plane, input bit drop_en);
        int rd = 0, edges = 0, lat = 0, low = 0, cyc = 0;
        int oe_bad = 0, latclk = 0, addr_bad = 0, fd_seen = 0;
        logic prev_clk;
        logic [4:0] prev_addr, lat_addr;
        bit fin = 0;
        string id;
        id = $sformatf("r%0d_p%0d", row, plane);
        prev_clk  = PCLK;
        prev_addr = {E, D, C, B, A};
        lat_addr  = '1;
        while (!fin && cyc < 20000) begin
            if (low > 0 && OE) begin
                fin = 1;
                chk({"frame_done_", id}, frame_done, (row == ROWS-1 && plane == BPP-1));
            end else begin
                if (fb_rd) begin
                    chk($sformatf("fb_addr_%s_c%0d", id, rd), fb_addr, row * COLS + rd);
                    rd++;
                    if (drop_en && rd == 10) en = 1'b0;
                end
                if (PCLK && !prev_clk) begin
                    if (edges < COLS) begin
                        chk($sformatf("rgb_%s_c%0d", id, edges), {B2, G2, R2, B1, G1, R1},
                            exp_bits(mem[row * COLS + edges], plane));
                        if (row == 0 && edges == 0)
                            chk({"r1_bcm_", id}, R1, (4'b0101 >> plane) & 4'b0001);
                    end
                    edges++;
                end
                if (PCLK && LAT) latclk++;
                if (!OE && (LAT || PCLK || edges < COLS)) oe_bad++;
                if ({E, D, C, B, A} != prev_addr && (!OE || LAT)) addr_bad++;
                if (LAT && lat == 0) lat_addr = {E, D, C, B, A};
                if (LAT) lat++;
                if (!OE) low++;
                if (frame_done) fd_seen++;
                prev_clk  = PCLK;
                prev_addr = {E, D, C, B, A};
                tick();
                cyc++;
            end
        end
        chk({"plane_complete_", id}, fin, 1);
        chk({"clk_edges_", id}, edges, COLS);
        chk({"reads_", id}, rd, COLS);
        chk({"lat_width_", id}, lat, CLK_DIV);
        chk({"row_addr_", id}, lat_addr, row);
        chk({"oe_width_", id}, low, BASE_ON << plane);
        chk({"oe_during_shift_", id}, oe_bad, 0);
        chk({"lat_and_clk_", id}, latclk, 0);
        chk({"addr_glitch_", id}, addr_bad, 0);
        chk({"early_frame_done_", id}, fd_seen, 0);
    endtask

    initial begin
        int n, bad, planes, fdc, fd_planes, fd_rise, fd_rd, fd_fbaddr;
        logic [4:0] fd_addr;
        logic pf;

        for (int i = 0; i < 2048; i++) mem[i] = 24'($urandom);
        for (int c = 0; c < COLS; c++) mem[c] = 24'h000F05;

        rst_n = 1'b0;
        en    = 1'b1;
        en_f  = 1'b0;
        repeat (3) tick();
        chk("rst_OE", OE, 1);
        chk("rst_LAT", LAT, 0);
        chk("rst_CLK", PCLK, 0);
        chk("rst_ABCDE", {E, D, C, B, A}, 0);
        chk("rst_fb_rd", fb_rd, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_rgb", {B2, G2, R2, B1, G1, R1}, 0);
        chk("rst_frame_done", frame_done, 0);

        rst_n = 1'b1;
        for (int r = 0; r < 5; r++)
            for (int p = 0; p < BPP; p++) observe_plane(r, p, 1'b0);
        observe_plane(5, 0, 1'b0);
        observe_plane(5, 1, 1'b0);
        observe_plane(5, 2, 1'b1);

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (fb_rd || PCLK || !OE || LAT) bad++;
            tick();
        end
        chk("idle_after_en_drop", bad, 0);

        en = 1'b1;
        observe_plane(0, 0, 1'b0);

        n = 0;
        while (OE && n < 2000) begin
            tick();
            n++;
        end
        chk("reach_display", OE, 0);
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        chk("midrst_OE", OE, 1);
        chk("midrst_LAT", LAT, 0);
        chk("midrst_CLK", PCLK, 0);
        chk("midrst_ABCDE", {E, D, C, B, A}, 0);
        chk("midrst_fb_rd", fb_rd, 0);
        chk("midrst_rgb", {B2, G2, R2, B1, G1, R1}, 0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_idle_OE", OE, 1);
        chk("post_rst_idle_rd", fb_rd, 0);

        en_f = 1'b1;
        n = 0; planes = 0; fdc = 0; fd_planes = -1; fd_rise = 0;
        fd_rd = 0; fd_fbaddr = -1; fd_addr = '0;
        pf = OE_f;
        while (n < 10000 && fdc == 0) begin
            tick();
            n++;
            if (OE_f && !pf) planes++;
            if (frame_done_f) begin
                fdc++;
                fd_planes = planes;
                fd_rise   = int'(OE_f && !pf);
                fd_addr   = {E_f, D_f, C_f, B_f, A_f};
                fd_rd     = int'(fb_rd_f);
                fd_fbaddr = int'(fb_addr_f);
            end
            pf = OE_f;
        end
        chk("frame_done_seen", fdc, 1);
        chk("frame_done_plane_count", fd_planes, 32 * BPP);
        chk("frame_done_with_oe_rise", fd_rise, 1);
        chk("frame_done_row_addr", fd_addr, 31);
        chk("next_shift_rd", fd_rd, 1);
        chk("next_shift_fb_addr", fd_fbaddr, 0);
        tick();
        chk("frame_done_width", frame_done_f, 0);
        en_f = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
